dsp_mac_sequencer: RTL and testbench

Control sequencer for one DSP48A1-style slice. It runs an N-beat multiply-accumulate (dot product) over A/B operand pairs. It drives the slice clock enables, the slice synchronous reset and OPMODE so the slice's A/B, M and P registers stay aligned with each accepted operand. It sits between a streaming operand source and the slice, and it registers the final P value as the result.

---
 rtl/dsp_mac_sequencer.sv | 143 ++++++++++++++
 tb/tb_dsp_mac_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dsp_mac_sequencer
// Function : N-beat MAC sequencer driving one DSP48A1-style slice.
//            Build option DSP_SEQ_PREADD_EN selects the (D+B)*A pre-adder path.
// Revision : 1.0
// ============================================================================
module dsp_mac_sequencer #(
  parameter int PIPE_LAT = 3,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ce_ab,
  output logic              ce_d,
  output logic              ce_m,
  output logic              ce_p,
  output logic              rst_slice,
  output logic [7:0]        opmode,
  input  logic [47:0]       p_in,
  output logic [47:0]       result,
  output logic              done
);

  localparam int c_depth = PIPE_LAT - 1;

  localparam logic [2:0] c_idle  = 3'd0;
  localparam logic [2:0] c_clear = 3'd1;
  localparam logic [2:0] c_accum = 3'd2;
  localparam logic [2:0] c_drain = 3'd3;
  localparam logic [2:0] c_done  = 3'd4;

`ifdef DSP_SEQ_PREADD_EN
  localparam logic [7:0] c_op_first = 8'h11;
  localparam logic [7:0] c_op_next  = 8'h19;
`else
  localparam logic [7:0] c_op_first = 8'h01;
  localparam logic [7:0] c_op_next  = 8'h09;
`endif

  logic [2:0]         r_state;
  logic [2:0]         w_next;
  logic [CNT_W-1:0]   r_remaining;
  logic               r_len_zero;
  logic               r_first;
  logic [c_depth-1:0] r_tok_v;
  logic [c_depth-1:0] r_tok_f;
  logic [47:0]        r_result;

  logic w_accept;
  logic w_last;
  logic w_pipe_empty;
  logic w_p_tok;
  logic w_p_first;

  assign w_accept     = (r_state == c_accum) && (r_remaining != '0) && in_valid;
  assign w_last       = w_accept && (r_remaining == CNT_W'(1));
  assign w_pipe_empty = (r_tok_v == '0);
  assign w_p_tok      = r_tok_v[c_depth-1];
  assign w_p_first    = r_tok_f[c_depth-1];

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_idle:  if (start) w_next = c_clear;
      c_clear: w_next = r_len_zero ? c_done : c_accum;
      c_accum: if (w_last) w_next = c_drain;
      // one extra cycle after the last P update lets p_in settle before capture
      c_drain: if (w_pipe_empty) w_next = c_done;
      c_done:  w_next = c_idle;
      default: w_next = c_idle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_idle;
      r_remaining <= '0;
      r_len_zero  <= 1'b0;
      r_first     <= 1'b0;
      r_tok_v     <= '0;
      r_tok_f     <= '0;
      r_result    <= '0;
    end else begin
      r_state <= w_next;

      if ((r_state == c_idle) && start) begin
        r_remaining <= len;
        r_len_zero  <= (len == '0);
      end else if (w_accept) begin
        r_remaining <= r_remaining - CNT_W'(1);
      end

      if (r_state == c_clear) begin
        r_first <= 1'b1;
      end else if (w_accept) begin
        r_first <= 1'b0;
      end

      // token pipe: stage k holds beats accepted k+1 cycles ago
      r_tok_v[0] <= w_accept;
      r_tok_f[0] <= w_accept && r_first;
      for (int i = 1; i < c_depth; i++) begin
        r_tok_v[i] <= r_tok_v[i-1];
        r_tok_f[i] <= r_tok_f[i-1];
      end

      if (r_state == c_done) begin
        r_result <= r_len_zero ? 48'd0 : p_in;
      end
    end
  end

  generate
    if (PIPE_LAT >= 3) begin : g_ce_m
      assign ce_m = r_tok_v[0];
    end else begin : g_no_ce_m
      assign ce_m = 1'b0;
    end
  endgenerate

`ifdef DSP_SEQ_PREADD_EN
  assign ce_d = w_accept;
`else
  assign ce_d = 1'b0;
`endif

  assign busy      = (r_state != c_idle);
  assign in_ready  = (r_state == c_accum) && (r_remaining != '0);
  assign ce_ab     = w_accept;
  assign ce_p      = w_p_tok;
  assign opmode    = w_p_tok ? (w_p_first ? c_op_first : c_op_next) : 8'h00;
  assign rst_slice = (r_state == c_clear);
  assign done      = (r_state == c_done);
  assign result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_dsp_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dsp_mac_sequencer
// Function : randomized self-checking bench with a cycle-schedule model and a
//            behavioural DSP slice; honours DSP_SEQ_PREADD_EN.
// Revision : 1.0
// ============================================================================
module tb_dsp_mac_sequencer;

  localparam int PIPE_LAT = 3;
  localparam int CNT_W    = 6;
  localparam int MAXC     = 8192;

`ifdef DSP_SEQ_PREADD_EN
  localparam logic [7:0]  OPF = 8'h11;
  localparam logic [7:0]  OPN = 8'h19;
  localparam int          FIX_LEN = 2;
  localparam logic [47:0] FIX_RES = 48'd32;
  localparam int          FIX_LAT = 7;
  localparam logic [17:0] FIX_A = 18'd4, FIX_B = 18'd3, FIX_D = 18'd1;
`else
  localparam logic [7:0]  OPF = 8'h01;
  localparam logic [7:0]  OPN = 8'h09;
  localparam int          FIX_LEN = 4;
  localparam logic [47:0] FIX_RES = 48'd24;
  localparam int          FIX_LAT = 9;
  localparam logic [17:0] FIX_A = 18'd2, FIX_B = 18'd3, FIX_D = 18'd0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic [CNT_W-1:0] len = '0;
  logic busy, in_ready, ce_ab, ce_d, ce_m, ce_p, rst_slice, done;
  logic [7:0]  opmode;
  logic [47:0] p_in, result;

  always #5 clk = ~clk;

  dsp_mac_sequencer #(.PIPE_LAT(PIPE_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .ce_ab(ce_ab), .ce_d(ce_d),
    .ce_m(ce_m), .ce_p(ce_p), .rst_slice(rst_slice), .opmode(opmode),
    .p_in(p_in), .result(result), .done(done)
  );

  function automatic logic [47:0] prod(input logic [17:0] a, input logic [17:0] b,
                                       input logic [17:0] d);
    logic [47:0] aa, bb, dd;
    aa = 48'(a); bb = 48'(b); dd = 48'(d);
`ifdef DSP_SEQ_PREADD_EN
    return (dd + bb) * aa;
`else
    return bb * aa + (dd & 48'd0);
`endif
  endfunction

  // behavioural slice: A/B/D regs, M reg, P accumulator
  logic [17:0] a_in = '0, b_in = '0, d_in = '0;
  logic [17:0] a_r = '0, b_r = '0, d_r = '0;
  logic [47:0] m_r = '0, p_r = '0;
  always @(posedge clk) begin
    if (rst_slice) begin
      a_r <= '0; b_r <= '0; d_r <= '0; m_r <= '0; p_r <= '0;
    end else begin
      if (ce_ab) begin a_r <= a_in; b_r <= b_in; end
      if (ce_d) d_r <= d_in;
      if (ce_m) m_r <= prod(a_r, b_r, d_r);
      if (ce_p) p_r <= ((opmode[3:2] == 2'b10) ? p_r : 48'd0) + m_r;
    end
  end
  assign p_in = p_r;

  // expected schedule, indexed by cycle number
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit        e_busy[MAXC], e_rdy[MAXC], e_ceab[MAXC], e_cem[MAXC];
  bit        e_cep[MAXC], e_rst[MAXC], e_done[MAXC], e_rupd[MAXC];
  bit [7:0]  e_opm[MAXC];
  bit [47:0] e_rval[MAXC];
  logic [47:0] exp_result = '0;

  int nchk = 0, nerr = 0, done_cnt = 0, obs_done = -1;
  bit spur = 1'b0, fixed_ops = 1'b0;

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      if (nerr <= 40)
        $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cyc < MAXC) begin
      if (e_rupd[cyc]) exp_result = e_rval[cyc];
      chk("busy", 48'(busy), 48'(e_busy[cyc]));
      chk("in_ready", 48'(in_ready), 48'(e_rdy[cyc]));
      chk("ce_ab", 48'(ce_ab), 48'(e_ceab[cyc]));
`ifdef DSP_SEQ_PREADD_EN
      chk("ce_d", 48'(ce_d), 48'(e_ceab[cyc]));
`else
      chk("ce_d", 48'(ce_d), 48'd0);
`endif
      chk("ce_m", 48'(ce_m), 48'(e_cem[cyc]));
      chk("ce_p", 48'(ce_p), 48'(e_cep[cyc]));
      chk("opmode", 48'(opmode), 48'(e_opm[cyc]));
      chk("rst_slice", 48'(rst_slice), 48'(e_rst[cyc]));
      chk("done", 48'(done), 48'(e_done[cyc]));
      chk("result", result, exp_result);
      if (done === 1'b1) begin
        done_cnt++;
        obs_done = cyc;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    in_valid = 1'($urandom_range(1));
    if (fixed_ops) begin
      a_in = FIX_A; b_in = FIX_B; d_in = FIX_D;
    end else begin
      a_in = 18'($urandom); b_in = 18'($urandom); d_in = 18'($urandom);
    end
    start = spur && ($urandom_range(2) == 0);
    len   = CNT_W'($urandom);
  endtask

  task automatic reset_now();
    int t;
    t = cyc;
    rst_n = 1'b0;
    for (int k = t; k < t + 24 && k < MAXC; k++) begin
      e_busy[k] = 0; e_rdy[k] = 0; e_ceab[k] = 0; e_cem[k] = 0;
      e_cep[k] = 0; e_rst[k] = 0; e_done[k] = 0; e_rupd[k] = 0; e_opm[k] = '0;
    end
    e_rupd[t] = 1; e_rval[t] = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // one sequence: start, clear, accept n beats with random gaps, drain, done
  task automatic run(input int n, input int vpct, input int bub_at, input int bub_n,
                     input int abort_at, output int s, output int d);
    int acc, t;
    bit first, v;
    logic [47:0] sum;
    sum = '0; acc = 0; first = 1; d = -1; done_cnt = 0;
    step(); s = cyc; start = 1'b1; len = CNT_W'(n);
    step(); e_busy[cyc] = 1; e_rst[cyc] = 1;
    if (n == 0) begin
      step(); d = cyc; e_busy[d] = 1; e_done[d] = 1;
      e_rupd[d+1] = 1; e_rval[d+1] = '0;
      return;
    end
    t = cyc;
    while (acc < n) begin
      step(); t = cyc;
      if (abort_at >= 0 && t - s == abort_at) begin
        reset_now();
        return;
      end
      e_busy[t] = 1; e_rdy[t] = 1;
      v = ($urandom_range(99) < vpct);
      if (acc == bub_at && bub_n > 0) begin v = 0; bub_n--; end
      if (t - s > 1000) v = 1;
      in_valid = v;
      if (v) begin
        e_ceab[t] = 1;
        if (PIPE_LAT >= 3) e_cem[t+1] = 1;
        e_cep[t+PIPE_LAT-1] = 1;
        e_opm[t+PIPE_LAT-1] = first ? OPF : OPN;
        sum = sum + prod(a_in, b_in, d_in);
        first = 0;
        acc++;
      end
    end
    for (int k = 1; k <= PIPE_LAT; k++) begin
      step(); e_busy[cyc] = 1;
    end
    step(); d = cyc; e_busy[d] = 1; e_done[d] = 1;
    e_rupd[d+1] = 1; e_rval[d+1] = sum;
  endtask

  initial begin
    int s, d;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // fixed operands, no bubbles
    fixed_ops = 1'b1;
    run(FIX_LEN, 100, -1, 0, -1, s, d);
    step();
    chk("fixed_result", result, FIX_RES);
    chk("fixed_latency", 48'(obs_done - s), 48'(FIX_LAT));
    chk("fixed_done_pulses", 48'(done_cnt), 48'd1);
    fixed_ops = 1'b0;

    // two-cycle bubble after the first beat
    run(3, 100, 1, 2, -1, s, d);
    step();
    chk("bubble_latency", 48'(obs_done - s), 48'd10);
    chk("bubble_done_pulses", 48'(done_cnt), 48'd1);

    // zero-length sequence
    run(0, 100, -1, 0, -1, s, d);
    step();
    chk("zero_result", result, 48'd0);
    chk("zero_latency", 48'(obs_done - s), 48'd2);

    // spurious start pulses while busy
    spur = 1'b1;
    run(5, 70, -1, 0, -1, s, d);
    spur = 1'b0;
    step();
    chk("spur_done_pulses", 48'(done_cnt), 48'd1);

    // reset in the middle of accumulation, then a full run
    run(6, 100, -1, 0, 4, s, d);
    step();
    chk("abort_done_pulses", 48'(done_cnt), 48'd0);
    chk("abort_busy", 48'(busy), 48'd0);
    run(3, 100, -1, 0, -1, s, d);
    step();
    chk("post_abort_done_pulses", 48'(done_cnt), 48'd1);

    // randomized sequences
    repeat (20) begin
      spur = 1'($urandom_range(1));
      run(int'($urandom_range(12)), int'($urandom_range(100, 30)),
          int'($urandom_range(3)), int'($urandom_range(2)), -1, s, d);
      spur = 1'b0;
      step();
      chk("rand_done_pulses", 48'(done_cnt), 48'd1);
      repeat ($urandom_range(2)) step();
    end

    // maximum count
    run((1 << CNT_W) - 1, 90, -1, 0, -1, s, d);
    step();
    chk("maxlen_done_pulses", 48'(done_cnt), 48'd1);
    step();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
`default_nettype wire
